reservation_station_mi: RTL and testbench

Multi-issue successor to the single-issue reservation station, sitting between dispatch and a cluster of ISSUE_WIDTH functional-unit ports.
- Holds up to RS_DEPTH instructions and wakes source operands from CDB_DEPTH result buses.
- Each cycle, issue port p receives the p-th oldest ready instruction.
- Oldest-first ordering comes from a true bit age matrix, not per-slot age counters.
- Adds a dispatch-cycle CDB bypass and per-port stall independence.

---
 rtl/reservation_station_mi.sv | 170 +++++++++++++++++
 tb/tb_reservation_station_mi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_mi.sv
// reservation_station_mi: multi-issue reservation station with CDB wakeup, dispatch bypass
// and age-matrix oldest-first selection across ISSUE_WIDTH ports.
package reservation_station_mi_pkg;
    typedef logic [6:0] opcode_t;
endpackage

module reservation_station_mi
    import reservation_station_mi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = 6,
    parameter int CDB_DEPTH   = 4,
    parameter int RS_DEPTH    = 8,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic                                       i_flush,
    input  logic [CDB_DEPTH-1:0]                       i_cdb_en,
    input  logic [CDB_DEPTH-1:0][DATA_WIDTH-1:0]       i_cdb_data,
    input  logic [CDB_DEPTH-1:0][TAG_WIDTH-1:0]        i_cdb_tag,
    input  logic                                       i_rs_en,
    input  opcode_t                                    i_rs_opcode,
    input  logic [ADDR_WIDTH-1:0]                      i_rs_iaddr,
    input  logic [DATA_WIDTH-1:0]                      i_rs_insn,
    input  logic [1:0][TAG_WIDTH-1:0]                  i_rs_src_tag,
    input  logic [1:0][DATA_WIDTH-1:0]                 i_rs_src_data,
    input  logic [1:0]                                 i_rs_src_rdy,
    input  logic [TAG_WIDTH-1:0]                       i_rs_dst_tag,
    output logic                                       o_rs_stall,
    output logic [$clog2(RS_DEPTH+1)-1:0]              o_rs_free_cnt,
    input  logic [ISSUE_WIDTH-1:0]                     i_fu_stall,
    output logic [ISSUE_WIDTH-1:0]                     o_fu_valid,
    output opcode_t [ISSUE_WIDTH-1:0]                  o_fu_opcode,
    output logic [ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0]     o_fu_iaddr,
    output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0]     o_fu_insn,
    output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0]     o_fu_src_a,
    output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0]     o_fu_src_b,
    output logic [ISSUE_WIDTH-1:0][TAG_WIDTH-1:0]      o_fu_tag
);
    localparam int CW = $clog2(RS_DEPTH + 1);

    logic [RS_DEPTH-1:0]                      empty_q, empty_d;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]        older_q, older_d;
    opcode_t [RS_DEPTH-1:0]                   opcode_q, opcode_d;
    logic [RS_DEPTH-1:0][ADDR_WIDTH-1:0]      iaddr_q, iaddr_d;
    logic [RS_DEPTH-1:0][DATA_WIDTH-1:0]      insn_q, insn_d;
    logic [RS_DEPTH-1:0][TAG_WIDTH-1:0]       dst_q, dst_d;
    logic [RS_DEPTH-1:0][1:0][TAG_WIDTH-1:0]  stag_q, stag_d;
    logic [RS_DEPTH-1:0][1:0][DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [RS_DEPTH-1:0][1:0]                 srdy_q, srdy_d;

    logic [RS_DEPTH-1:0]                      ready, avail, issued, disp_sel;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]     sel;
    logic                                     blocked, disp;
    logic [DATA_WIDTH:0]                      hit_w, hit_b;

    // Lowest-indexed enabled bus wins when several carry the same tag.
    function automatic logic [DATA_WIDTH:0] cdb_lookup(input logic [TAG_WIDTH-1:0] tag);
        logic [DATA_WIDTH:0] r = '0;
        for (int c = CDB_DEPTH - 1; c >= 0; c--)
            if (i_cdb_en[c] && i_cdb_tag[c] == tag) r = {1'b1, i_cdb_data[c]};
        return r;
    endfunction

    assign o_rs_stall = ~|empty_q;
    assign disp       = i_rs_en & ~o_rs_stall & ~i_flush;
    assign disp_sel   = empty_q & (~empty_q + RS_DEPTH'(1));

    always_comb begin
        o_rs_free_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++) o_rs_free_cnt += CW'(empty_q[i]);
    end

    // Each port takes the slot with no older ready slot left unclaimed by lower ports.
    always_comb begin
        blocked = 1'b0;
        sel     = '0;
        for (int i = 0; i < RS_DEPTH; i++) ready[i] = ~empty_q[i] & (&srdy_q[i]);
        avail = ready;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                blocked = 1'b0;
                for (int j = 0; j < RS_DEPTH; j++)
                    if (j != i) blocked = blocked | (avail[j] & older_q[j][i]);
                sel[p][i] = avail[i] & ~blocked;
            end
            avail = avail & ~sel[p];
        end
    end

    always_comb begin
        o_fu_valid  = '0;
        o_fu_opcode = '0;
        o_fu_iaddr  = '0;
        o_fu_insn   = '0;
        o_fu_src_a  = '0;
        o_fu_src_b  = '0;
        o_fu_tag    = '0;
        issued      = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            o_fu_valid[p] = |sel[p] & ~i_flush;
            issued = issued | (sel[p] & {RS_DEPTH{o_fu_valid[p] & ~i_fu_stall[p]}});
            for (int i = 0; i < RS_DEPTH; i++)
                if (sel[p][i]) begin
                    o_fu_opcode[p] = opcode_q[i];
                    o_fu_iaddr[p]  = iaddr_q[i];
                    o_fu_insn[p]   = insn_q[i];
                    o_fu_src_a[p]  = sdata_q[i][0];
                    o_fu_src_b[p]  = sdata_q[i][1];
                    o_fu_tag[p]    = dst_q[i];
                end
        end
    end

    always_comb begin
        empty_d  = i_flush ? '1 : (empty_q | issued) & ~(disp_sel & {RS_DEPTH{disp}});
        older_d  = older_q;
        opcode_d = opcode_q;
        iaddr_d  = iaddr_q;
        insn_d   = insn_q;
        dst_d    = dst_q;
        stag_d   = stag_q;
        sdata_d  = sdata_q;
        srdy_d   = srdy_q;
        hit_w    = '0;
        hit_b    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                hit_w = cdb_lookup(stag_q[i][k]);
                if (!srdy_q[i][k] && hit_w[DATA_WIDTH]) begin
                    srdy_d[i][k]  = 1'b1;
                    sdata_d[i][k] = hit_w[DATA_WIDTH-1:0];
                end
                if (disp && disp_sel[i]) begin
                    hit_b         = cdb_lookup(i_rs_src_tag[k]);
                    stag_d[i][k]  = i_rs_src_tag[k];
                    srdy_d[i][k]  = i_rs_src_rdy[k] | hit_b[DATA_WIDTH];
                    sdata_d[i][k] = (i_rs_src_rdy[k] | ~hit_b[DATA_WIDTH]) ? i_rs_src_data[k] : hit_b[DATA_WIDTH-1:0];
                end
            end
            if (disp && disp_sel[i]) begin
                opcode_d[i] = i_rs_opcode;
                iaddr_d[i]  = i_rs_iaddr;
                insn_d[i]   = i_rs_insn;
                dst_d[i]    = i_rs_dst_tag;
                older_d[i]  = '0;
                for (int j = 0; j < RS_DEPTH; j++)
                    if (j != i) older_d[j][i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) empty_q <= '1;
        else        empty_q <= empty_d;

    // Payload and age bits are only meaningful while a slot is occupied.
    always_ff @(posedge clk) begin
        older_q  <= older_d;
        opcode_q <= opcode_d;
        iaddr_q  <= iaddr_d;
        insn_q   <= insn_d;
        dst_q    <= dst_d;
        stag_q   <= stag_d;
        sdata_q  <= sdata_d;
        srdy_q   <= srdy_d;
    end
endmodule

// File: tb/tb_reservation_station_mi.sv
// tb_reservation_station_mi: directed vector table, corner sequences and randomized traffic
// checked against a dispatch-ordered queue model of the reservation station.
module tb_reservation_station_mi;
    import reservation_station_mi_pkg::*;
    localparam int DW = 32, AW = 32, TW = 6, CD = 4, RS = 8, IW = 2;

    logic                      clk = 1'b0, n_rst = 1'b0, i_flush = 1'b0;
    logic [CD-1:0]             i_cdb_en = '0;
    logic [CD-1:0][DW-1:0]     i_cdb_data = '0;
    logic [CD-1:0][TW-1:0]     i_cdb_tag = '0;
    logic                      i_rs_en = 1'b0;
    opcode_t                   i_rs_opcode = '0;
    logic [AW-1:0]             i_rs_iaddr = '0;
    logic [DW-1:0]             i_rs_insn = '0;
    logic [1:0][TW-1:0]        i_rs_src_tag = '0;
    logic [1:0][DW-1:0]        i_rs_src_data = '0;
    logic [1:0]                i_rs_src_rdy = '0;
    logic [TW-1:0]             i_rs_dst_tag = '0;
    logic                      o_rs_stall;
    logic [$clog2(RS+1)-1:0]   o_rs_free_cnt;
    logic [IW-1:0]             i_fu_stall = '0;
    logic [IW-1:0]             o_fu_valid;
    opcode_t [IW-1:0]          o_fu_opcode;
    logic [IW-1:0][AW-1:0]     o_fu_iaddr;
    logic [IW-1:0][DW-1:0]     o_fu_insn, o_fu_src_a, o_fu_src_b;
    logic [IW-1:0][TW-1:0]     o_fu_tag;

    reservation_station_mi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .CDB_DEPTH(CD),
                             .RS_DEPTH(RS), .ISSUE_WIDTH(IW)) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_cdb_en(i_cdb_en), .i_cdb_data(i_cdb_data),
        .i_cdb_tag(i_cdb_tag), .i_rs_en(i_rs_en), .i_rs_opcode(i_rs_opcode), .i_rs_iaddr(i_rs_iaddr),
        .i_rs_insn(i_rs_insn), .i_rs_src_tag(i_rs_src_tag), .i_rs_src_data(i_rs_src_data),
        .i_rs_src_rdy(i_rs_src_rdy), .i_rs_dst_tag(i_rs_dst_tag), .o_rs_stall(o_rs_stall),
        .o_rs_free_cnt(o_rs_free_cnt), .i_fu_stall(i_fu_stall), .o_fu_valid(o_fu_valid),
        .o_fu_opcode(o_fu_opcode), .o_fu_iaddr(o_fu_iaddr), .o_fu_insn(o_fu_insn),
        .o_fu_src_a(o_fu_src_a), .o_fu_src_b(o_fu_src_b), .o_fu_tag(o_fu_tag));

    always #5 clk = ~clk;

    typedef struct packed {
        opcode_t            op;
        logic [AW-1:0]      ia;
        logic [DW-1:0]      insn;
        logic [1:0][TW-1:0] st;
        logic [1:0][DW-1:0] sd;
        logic [1:0]         rdy;
        logic [TW-1:0]      dst;
    } ent_t;

    typedef struct {
        int en, rdy, st0, st1, dst, fst, cv, ci, ct, cd;
        int efree, ev, et0, et1, chks, ea0, eb0;
    } vec_t;

    ent_t q[$];
    int   pick[IW];
    int   checks = 0, failures = 0;
    vec_t tv[20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void wake(inout ent_t e);
        for (int k = 0; k < 2; k++)
            if (!e.rdy[k])
                for (int c = 0; c < CD; c++)
                    if (i_cdb_en[c] && i_cdb_tag[c] == e.st[k]) begin
                        e.rdy[k] = 1'b1;
                        e.sd[k]  = i_cdb_data[c];
                        break;
                    end
    endfunction

    // Port p presents the p-th oldest ready entry in dispatch order.
    task automatic check_model();
        int n = 0;
        bit ev;
        for (int p = 0; p < IW; p++) pick[p] = -1;
        for (int i = 0; i < q.size(); i++)
            if (&q[i].rdy && n < IW) begin
                pick[n] = i;
                n++;
            end
        chk("stall", o_rs_stall, q.size() == RS);
        chk("free_cnt", o_rs_free_cnt, RS - q.size());
        for (int p = 0; p < IW; p++) begin
            ev = !i_flush && pick[p] >= 0;
            chk("fu_valid", o_fu_valid[p], ev);
            if (ev)
                chk("fu_payload", {o_fu_opcode[p], o_fu_iaddr[p], o_fu_insn[p], o_fu_src_a[p], o_fu_src_b[p], o_fu_tag[p]},
                    {q[pick[p]].op, q[pick[p]].ia, q[pick[p]].insn, q[pick[p]].sd[0], q[pick[p]].sd[1], q[pick[p]].dst});
        end
    endtask

    task automatic advance();
        bit [RS-1:0] kill = '0;
        int   sz;
        ent_t ne, e;
        @(posedge clk);
        sz = q.size();
        if (!n_rst) q.delete();
        else begin
            if (!i_flush)
                for (int p = 0; p < IW; p++)
                    if (pick[p] >= 0 && !i_fu_stall[p]) kill[pick[p]] = 1'b1;
            for (int i = 0; i < sz; i++) begin
                e = q[i];
                wake(e);
                q[i] = e;
            end
            ne = '{op: i_rs_opcode, ia: i_rs_iaddr, insn: i_rs_insn, st: i_rs_src_tag,
                   sd: i_rs_src_data, rdy: i_rs_src_rdy, dst: i_rs_dst_tag};
            wake(ne);
            for (int i = sz - 1; i >= 0; i--) if (kill[i]) q.delete(i);
            if (i_rs_en && sz < RS && !i_flush) q.push_back(ne);
            if (i_flush) q.delete();
        end
        #1;
    endtask

    task automatic drive(input int en, input int rdy, input int t0, input int t1, input int dst,
                         input int fst, input int fl);
        i_rs_en          = 1'(en);
        i_rs_src_rdy     = 2'(rdy);
        i_rs_src_tag[0]  = TW'(t0);
        i_rs_src_tag[1]  = TW'(t1);
        i_rs_dst_tag     = TW'(dst);
        i_rs_src_data[0] = DW'(32'hA000 + dst);
        i_rs_src_data[1] = DW'(32'hB000 + dst);
        i_rs_opcode      = opcode_t'(dst + 3);
        i_rs_iaddr       = AW'(32'h1000 + 4 * dst);
        i_rs_insn        = DW'(32'h0013_0000 + dst);
        i_fu_stall       = IW'(fst);
        i_flush          = 1'(fl);
        i_cdb_en         = '0;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        advance();
    endtask

    initial begin
        //       en rdy st0 st1 dst fst cv ci ct cd       free ev et0 et1 chks ea0     eb0
        tv[0]  = '{1, 3, 0, 0, 1, 3, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 3, 0, 0, 2, 3, 0, 0, 0, 0,          7, 1, 1, 0, 0, 0, 0};
        tv[2]  = '{1, 3, 0, 0, 3, 3, 0, 0, 0, 0,          6, 3, 1, 2, 0, 0, 0};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          5, 3, 1, 2, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          7, 1, 3, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{1, 1, 0, 9, 4, 0, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{1, 3, 0, 0, 5, 0, 0, 0, 0, 0,          7, 0, 0, 0, 0, 0, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 9, 'hDEAD,     6, 1, 5, 0, 0, 0, 0};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          7, 1, 4, 0, 1, 'hA004, 'hDEAD};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 2, 5, 0, 6, 0, 1, 2, 5, 'h1234,     8, 0, 0, 0, 0, 0, 0};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          7, 1, 6, 0, 1, 'h1234, 'hB006};
        tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[14] = '{1, 3, 0, 0, 7, 3, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};
        tv[15] = '{1, 3, 0, 0, 8, 3, 0, 0, 0, 0,          7, 1, 7, 0, 0, 0, 0};
        tv[16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          6, 3, 7, 8, 0, 0, 0};
        tv[17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          7, 1, 7, 0, 0, 0, 0};
        tv[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          7, 1, 7, 0, 0, 0, 0};
        tv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          8, 0, 0, 0, 0, 0, 0};

        @(negedge clk);
        chk("reset_valid", o_fu_valid, 0);
        chk("reset_free", o_rs_free_cnt, RS);
        chk("reset_stall", o_rs_stall, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        for (int v = 0; v < 20; v++) begin
            drive(tv[v].en, tv[v].rdy, tv[v].st0, tv[v].st1, tv[v].dst, tv[v].fst, 0);
            if (tv[v].cv != 0) begin
                i_cdb_en[tv[v].ci]   = 1'b1;
                i_cdb_tag[tv[v].ci]  = TW'(tv[v].ct);
                i_cdb_data[tv[v].ci] = DW'(tv[v].cd);
            end
            @(negedge clk);
            check_model();
            chk("vec_free", o_rs_free_cnt, tv[v].efree);
            chk("vec_valid", o_fu_valid, tv[v].ev);
            if (tv[v].ev & 1) chk("vec_tag0", o_fu_tag[0], tv[v].et0);
            if (tv[v].ev & 2) chk("vec_tag1", o_fu_tag[1], tv[v].et1);
            if (tv[v].chks != 0) begin
                chk("vec_src_a0", o_fu_src_a[0], tv[v].ea0);
                chk("vec_src_b0", o_fu_src_b[0], tv[v].eb0);
            end
            advance();
        end

        // Fill to capacity; an extra request while full must be ignored.
        for (int i = 0; i < RS; i++) begin
            drive(1, 3, 0, 0, 10 + i, 3, 0);
            step();
        end
        drive(1, 3, 0, 0, 30, 3, 0);
        @(negedge clk);
        check_model();
        chk("full_stall", o_rs_stall, 1);
        chk("full_free", o_rs_free_cnt, 0);
        advance();
        drive(0, 0, 0, 0, 0, 2, 0);
        @(negedge clk);
        check_model();
        chk("full_tag0", o_fu_tag[0], 10);
        advance();
        drive(1, 3, 0, 0, 40, 3, 0);
        @(negedge clk);
        check_model();
        chk("refill_stall", o_rs_stall, 0);
        chk("refill_free", o_rs_free_cnt, 1);
        advance();
        drive(0, 0, 0, 0, 0, 3, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 3, 0, 0, 50, 0, 1);
        @(negedge clk);
        check_model();
        chk("flush_valid", o_fu_valid, 0);
        advance();
        drive(0, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        check_model();
        chk("post_flush_free", o_rs_free_cnt, RS);
        chk("post_flush_valid", o_fu_valid, 0);
        advance();

        // Asynchronous reset between edges with ready work pending.
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 0, 0, 20 + i, 3, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_valid", o_fu_valid, 0);
        chk("async_rst_free", o_rs_free_cnt, RS);
        chk("async_rst_stall", o_rs_stall, 0);
        q.delete();
        step();
        n_rst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            i_rs_en         = ($urandom % 4) != 0;
            i_rs_opcode     = opcode_t'($urandom);
            i_rs_iaddr      = AW'($urandom);
            i_rs_insn       = DW'($urandom);
            i_rs_src_tag[0] = TW'($urandom % 8);
            i_rs_src_tag[1] = TW'($urandom % 8);
            i_rs_src_data   = {DW'($urandom), DW'($urandom)};
            i_rs_src_rdy    = 2'($urandom);
            i_rs_dst_tag    = TW'($urandom);
            i_fu_stall      = IW'($urandom);
            i_flush         = ($urandom % 64) == 0;
            for (int c = 0; c < CD; c++) begin
                i_cdb_en[c]   = ($urandom % 3) == 0;
                i_cdb_tag[c]  = TW'($urandom % 8);
                i_cdb_data[c] = DW'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
